// File: rtl/rv32_run_ctrl_if.sv
// Control/status bundle between the debug side (master) and the RV32 run controller (slave).
interface rv32_run_ctrl_if #(
    parameter int unsigned NUM_BP = 2,
    parameter int unsigned CNT_W  = 32
);
    logic                   run_req;
    logic                   halt_req;
    logic                   step_req;
    logic                   cnt_clr;
    logic [NUM_BP-1:0]      bp_en;
    logic [NUM_BP*32-1:0]   bp_addr;
    logic [31:0]            cur_pc;
    logic                   stop_en;
    logic                   commit;
    logic                   running;
    logic                   halted;
    logic [1:0]             halt_cause;
    logic [1:0]             bp_hit_idx;
    logic [CNT_W-1:0]       cycle_cnt;
    logic [CNT_W-1:0]       instret_cnt;

    modport master (
        output run_req, halt_req, step_req, cnt_clr, bp_en, bp_addr, cur_pc,
        input  stop_en, commit, running, halted, halt_cause, bp_hit_idx, cycle_cnt, instret_cnt
    );

    modport slave (
        input  run_req, halt_req, step_req, cnt_clr, bp_en, bp_addr, cur_pc,
        output stop_en, commit, running, halted, halt_cause, bp_hit_idx, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/rv32_run_ctrl.sv
// Run controller for the single-cycle RV32 core: halt/run/step, PC breakpoints,
// a PC-freeze output with a commit qualifier, and cycle/instret counters.
module rv32_run_ctrl #(
    parameter int unsigned NUM_BP   = 2,
    parameter int unsigned CNT_W    = 32,
    parameter bit          AUTO_RUN = 1'b0
) (
    input logic            clk,
    input logic            rst,
    rv32_run_ctrl_if.slave ctl
);
    typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

    localparam state_e ResetState = AUTO_RUN ? StRun : StHalt;

    state_e           state_q;
    logic             skip_q;
    logic [1:0]       cause_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    logic       bp_match;
    logic [1:0] bp_idx;
    logic       bp_stop;
    logic       stop;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        bp_match = 1'b0;
        bp_idx   = 2'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (ctl.bp_en[i] && (ctl.cur_pc == ctl.bp_addr[32*i +: 32])) begin
                bp_match = 1'b1;
                bp_idx   = 2'(i);
            end
        end
    end

    assign bp_stop = bp_match && !skip_q;

    always_comb begin
        stop = 1'b1;
        if (!rst) begin
            case (state_q)
                StHalt:  stop = 1'b1;
                StStep:  stop = 1'b0;
                StRun:   stop = ctl.halt_req || bp_stop;
                default: stop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ResetState;
            skip_q  <= 1'b1;
            cause_q <= 2'b00;
            idx_q   <= 2'd0;
        end else begin
            case (state_q)
                StHalt: begin
                    if (!ctl.halt_req) begin
                        if (ctl.step_req) begin
                            state_q <= StStep;
                        end else if (ctl.run_req) begin
                            state_q <= StRun;
                            skip_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // Breakpoint suppression covers only the first cycle after a resume.
                    skip_q <= 1'b0;
                    if (bp_stop) begin
                        state_q <= StHalt;
                        cause_q <= 2'b10;
                        idx_q   <= bp_idx;
                    end else if (ctl.halt_req) begin
                        state_q <= StHalt;
                        cause_q <= 2'b01;
                    end
                end
                StStep: begin
                    state_q <= StHalt;
                    cause_q <= 2'b11;
                end
                default: state_q <= StHalt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ctl.cnt_clr) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_q + 1'b1;
            instret_q <= instret_q + CNT_W'(!stop);
        end
    end

    assign ctl.stop_en     = stop;
    assign ctl.commit      = !stop;
    assign ctl.running     = (state_q == StRun);
    assign ctl.halted      = (state_q == StHalt);
    assign ctl.halt_cause  = cause_q;
    assign ctl.bp_hit_idx  = idx_q;
    assign ctl.cycle_cnt   = cycle_q;
    assign ctl.instret_cnt = instret_q;
endmodule

// File: tb/tb_rv32_run_ctrl.sv
// Bench for rv32_run_ctrl: a tiny PC model plus a per-cycle expected-output scoreboard
// and scenario tasks with spot checks.
module tb_rv32_run_ctrl;
    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;

    rv32_run_ctrl_if #(.NUM_BP(2), .CNT_W(CW)) ctl ();

    rv32_run_ctrl #(.NUM_BP(2), .CNT_W(CW), .AUTO_RUN(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ctl)
    );

    always #5 clk = ~clk;

    assign ctl.cur_pc = pc;

    // Stand-in for the core PC register: advances unless frozen.
    always @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else if (!ctl.stop_en) pc <= pc + 32'd4;
    end

    typedef struct packed {
        logic          rst;
        logic          stop;
        logic          run;
        logic          hlt;
        logic [1:0]    cause;
        logic [1:0]    idx;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ins;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   sb_on = 1'b0;

    int            m_st;  // 0 halt, 1 run, 2 step
    logic [1:0]    m_cause;
    logic [1:0]    m_idx;
    bit            m_skip;
    logic [CW-1:0] m_cyc;
    logic [CW-1:0] m_ins;

    task automatic tick(input bit r, input bit run, input bit hlt, input bit stp, input bit clr);
        bit         match;
        logic [1:0] hidx;
        bit         stop;
        exp_t       e;
        rst          = r;
        ctl.run_req  = run;
        ctl.halt_req = hlt;
        ctl.step_req = stp;
        ctl.cnt_clr  = clr;
        match = 1'b0;
        hidx  = 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (!match && ctl.bp_en[i] && pc == ctl.bp_addr[32*i +: 32]) begin
                match = 1'b1;
                hidx  = 2'(i);
            end
        end
        if (r) stop = 1'b1;
        else if (m_st == 0) stop = 1'b1;
        else if (m_st == 2) stop = 1'b0;
        else stop = hlt || (match && !m_skip);
        e = '{r, stop, (m_st == 1), (m_st == 0), m_cause, m_idx, m_cyc, m_ins};
        if (sb_on) sb.push_back(e);
        if (r) begin
            m_st = 0; m_cause = 2'b00; m_idx = 2'd0; m_skip = 1'b1; m_cyc = '0; m_ins = '0;
        end else begin
            if (clr) begin
                m_cyc = '0;
                m_ins = '0;
            end else begin
                m_cyc = m_cyc + 1'b1;
                if (!stop) m_ins = m_ins + 1'b1;
            end
            case (m_st)
                0: begin
                    if (!hlt && stp) m_st = 2;
                    else if (!hlt && run) begin m_st = 1; m_skip = 1'b1; end
                end
                1: begin
                    if (match && !m_skip) begin m_st = 0; m_cause = 2'b10; m_idx = hidx; end
                    else if (hlt) begin m_st = 0; m_cause = 2'b01; end
                    m_skip = 1'b0;
                end
                default: begin m_st = 0; m_cause = 2'b11; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            n_vec++;
            if (ctl.stop_en !== got_e.stop) begin
                n_bad++; $display("FAIL sb_stop_en t=%0t got %b exp %b", $time, ctl.stop_en, got_e.stop);
            end
            n_vec++;
            if (ctl.commit !== !got_e.stop) begin
                n_bad++; $display("FAIL sb_commit t=%0t got %b exp %b", $time, ctl.commit, !got_e.stop);
            end
            if (!got_e.rst) begin
                n_vec++;
                if ({ctl.running, ctl.halted} !== {got_e.run, got_e.hlt}) begin
                    n_bad++;
                    $display("FAIL sb_state t=%0t got run/halt %b%b exp %b%b", $time,
                             ctl.running, ctl.halted, got_e.run, got_e.hlt);
                end
                n_vec++;
                if ({ctl.halt_cause, ctl.bp_hit_idx} !== {got_e.cause, got_e.idx}) begin
                    n_bad++;
                    $display("FAIL sb_cause t=%0t got cause/idx %b/%0d exp %b/%0d", $time,
                             ctl.halt_cause, ctl.bp_hit_idx, got_e.cause, got_e.idx);
                end
                n_vec++;
                if ({ctl.cycle_cnt, ctl.instret_cnt} !== {got_e.cyc, got_e.ins}) begin
                    n_bad++;
                    $display("FAIL sb_counters t=%0t got cyc/ins %0d/%0d exp %0d/%0d", $time,
                             ctl.cycle_cnt, ctl.instret_cnt, got_e.cyc, got_e.ins);
                end
            end
        end
    end

    task automatic test_reset();
        tick(1, 0, 0, 0, 0);
        sb_on = 1'b1;
        tick(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || ctl.stop_en !== 1'b1) begin
            n_bad++; $display("FAIL reset_halted got halted=%b stop_en=%b exp 1/1", ctl.halted, ctl.stop_en);
        end
        n_vec++;
        if (ctl.halt_cause !== 2'b00 || ctl.instret_cnt !== 4'd0 || ctl.cycle_cnt !== 4'd10) begin
            n_bad++;
            $display("FAIL reset_idle got cause=%b ins=%0d cyc=%0d exp 00/0/10",
                     ctl.halt_cause, ctl.instret_cnt, ctl.cycle_cnt);
        end
    endtask

    task automatic test_step();
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || ctl.halt_cause !== 2'b11 || ctl.instret_cnt !== 4'd1 || pc !== 32'h4) begin
            n_bad++;
            $display("FAIL step_one got halted=%b cause=%b ins=%0d pc=%h exp 1/11/1/00000004",
                     ctl.halted, ctl.halt_cause, ctl.instret_cnt, pc);
        end
        for (int k = 0; k < 3; k++) begin
            tick(0, 0, 0, 1, 0);
            tick(0, 0, 0, 0, 0);
        end
        n_vec++;
        if (ctl.instret_cnt !== 4'd4 || pc !== 32'h10) begin
            n_bad++; $display("FAIL step_four got ins=%0d pc=%h exp 4/00000010", ctl.instret_cnt, pc);
        end
    endtask

    task automatic test_breakpoint();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        ctl.bp_en   = 2'b01;
        ctl.bp_addr = {32'h100, 32'h10};
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 20 && !ctl.halted; k++) tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || pc !== 32'h10) begin
            n_bad++; $display("FAIL bp_halt got halted=%b pc=%h exp 1/00000010", ctl.halted, pc);
        end
        n_vec++;
        if (ctl.halt_cause !== 2'b10 || ctl.bp_hit_idx !== 2'd0 || ctl.instret_cnt !== 4'd4) begin
            n_bad++;
            $display("FAIL bp_status got cause=%b idx=%0d ins=%0d exp 10/0/4",
                     ctl.halt_cause, ctl.bp_hit_idx, ctl.instret_cnt);
        end
    endtask

    task automatic test_resume();
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.running !== 1'b1 || pc !== 32'h1c) begin
            n_bad++; $display("FAIL resume_past_bp got running=%b pc=%h exp 1/0000001c", ctl.running, pc);
        end
        tick(0, 0, 1, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || ctl.halt_cause !== 2'b01 || pc !== 32'h1c) begin
            n_bad++;
            $display("FAIL halt_req got halted=%b cause=%b pc=%h exp 1/01/0000001c", ctl.halted, ctl.halt_cause, pc);
        end
        ctl.bp_addr[31:0] = 32'h1c;
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        n_vec++;
        if (pc !== 32'h20 || ctl.halt_cause !== 2'b11) begin
            n_bad++; $display("FAIL step_off_bp got pc=%h cause=%b exp 00000020/11", pc, ctl.halt_cause);
        end
    endtask

    task automatic test_simultaneous();
        ctl.bp_en   = 2'b11;
        ctl.bp_addr = {32'h28, 32'h28};
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || ctl.halt_cause !== 2'b10 || ctl.bp_hit_idx !== 2'd0 || pc !== 32'h28) begin
            n_bad++;
            $display("FAIL bp_and_halt got halted=%b cause=%b idx=%0d pc=%h exp 1/10/0/00000028",
                     ctl.halted, ctl.halt_cause, ctl.bp_hit_idx, pc);
        end
        ctl.bp_en   = 2'b10;
        ctl.bp_addr = {32'h30, 32'h28};
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 10 && !ctl.halted; k++) tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || ctl.bp_hit_idx !== 2'd1 || pc !== 32'h30) begin
            n_bad++;
            $display("FAIL bp_idx1 got halted=%b idx=%0d pc=%h exp 1/1/00000030", ctl.halted, ctl.bp_hit_idx, pc);
        end
        tick(0, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || pc !== 32'h30 || ctl.halt_cause !== 2'b10) begin
            n_bad++;
            $display("FAIL halt_plus_step got halted=%b pc=%h cause=%b exp 1/00000030/10",
                     ctl.halted, pc, ctl.halt_cause);
        end
    endtask

    task automatic test_counters();
        ctl.bp_en = 2'b00;
        tick(0, 0, 0, 0, 1);
        n_vec++;
        if (ctl.cycle_cnt !== 4'd0 || ctl.instret_cnt !== 4'd0) begin
            n_bad++; $display("FAIL cnt_clr got cyc=%0d ins=%0d exp 0/0", ctl.cycle_cnt, ctl.instret_cnt);
        end
        tick(0, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) tick(0, 0, 0, 0, 0);
        n_vec++;
        if (ctl.cycle_cnt !== 4'd1 || ctl.instret_cnt !== 4'd0 || ctl.running !== 1'b1) begin
            n_bad++;
            $display("FAIL cnt_wrap got cyc=%0d ins=%0d running=%b exp 1/0/1",
                     ctl.cycle_cnt, ctl.instret_cnt, ctl.running);
        end
        tick(1, 0, 0, 0, 0);
        n_vec++;
        if (ctl.halted !== 1'b1 || ctl.running !== 1'b0 || pc !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_run got halted=%b running=%b pc=%h exp 1/0/00000000", ctl.halted, ctl.running, pc);
        end
        tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        ctl.bp_en    = 2'b00;
        ctl.bp_addr  = '0;
        ctl.run_req  = 1'b0;
        ctl.halt_req = 1'b0;
        ctl.step_req = 1'b0;
        ctl.cnt_clr  = 1'b0;
        test_reset();
        test_step();
        test_breakpoint();
        test_resume();
        test_simultaneous();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
